// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, controller states and default watchdog limit
package muldiv_pkg;
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;
  localparam int DEF_TIMEOUT = 40;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/muldiv_timer.sv
// muldiv_timer: wait-cycle counter; expired is high during the TIMEOUT-th enabled cycle
module muldiv_timer #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] count;
  assign expired = count == CW'(TIMEOUT - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable && !expired) count <= count + CW'(1);
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences iterative mult/div units and owns architectural HI/LO
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             mult_start,
  output logic             div_start,
  input  logic             mult_done,
  input  logic             div_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             timeout_err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_e state, state_n;
  logic [1:0] op_q, op_n;
  logic [WIDTH-1:0] a_n, b_n, hi_n, lo_n;
  logic ms_n, ds_n, done_n, dz_n, to_n, clr, en, expired, sel_done;
  muldiv_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock(clock), .reset(reset), .clear(clr), .enable(en), .expired(expired)
  );
  assign sel_done = op_q == OP_MULT ? mult_done : div_done;
  always_comb begin
    state_n = state;
    op_n = op_q;
    a_n = unit_a;
    b_n = unit_b;
    hi_n = hi;
    lo_n = lo;
    ms_n = 1'b0;
    ds_n = 1'b0;
    done_n = 1'b0;
    dz_n = 1'b0;
    to_n = 1'b0;
    clr = 1'b0;
    en = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        if (op == OP_MTHI) {hi_n, done_n} = {rs_data, 1'b1};
        else if (op == OP_MTLO) {lo_n, done_n} = {rs_data, 1'b1};
        else if (op == OP_DIV && rt_data == '0) dz_n = 1'b1;
        else begin
          {a_n, b_n, op_n, state_n} = {rs_data, rt_data, op, S_LAUNCH};
          ms_n = op == OP_MULT;
          ds_n = op == OP_DIV;
        end
      end
      S_LAUNCH: {clr, state_n} = {1'b1, S_WAIT};
      S_WAIT: begin
        en = 1'b1;
        // a unit done in the expiry cycle still commits
        if (sel_done) begin
          hi_n = op_q == OP_MULT ? mult_hi : div_hi;
          lo_n = op_q == OP_MULT ? mult_lo : div_lo;
          state_n = S_DONE;
          done_n = 1'b1;
        end else if (expired) {to_n, state_n} = {1'b1, S_IDLE};
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      op_q <= OP_MULT;
      {unit_a, unit_b, hi, lo} <= '0;
      {mult_start, div_start, done, div_zero, timeout_err, busy} <= '0;
    end else begin
      state <= state_n;
      op_q <= op_n;
      {unit_a, unit_b, hi, lo} <= {a_n, b_n, hi_n, lo_n};
      {mult_start, div_start, done, div_zero, timeout_err} <= {ms_n, ds_n, done_n, dz_n, to_n};
      busy <= state_n != S_IDLE;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer and HI/LO owner for the iterative multiply and divide units of the multi-cycle MIPS datapath. It accepts MULT/DIV/MTHI/MTLO requests from the main control FSM and latches the operands. It launches the selected iterative unit with a one-cycle start pulse, waits for its done, and commits the 64-bit result to the architectural HI/LO registers. It reports busy, completion, divide-by-zero and a watchdog timeout back to the control FSM.

## Interface
- WIDTH, 32, operand and HI/LO width
- TIMEOUT, 40, maximum WAIT cycles before the watchdog trips

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  request strobe, sampled only in IDLE
- op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
- rs_data  in  WIDTH  first operand / MTHI/MTLO source
- rt_data  in  WIDTH  second operand (multiplier / divisor)
- unit_a, unit_b  out  WIDTH  registered operands to both units
- mult_start, div_start  out  1  one-cycle launch pulses
- mult_done, div_done  in  1  unit completion strobes
- mult_hi, mult_lo  in  WIDTH  product halves
- div_hi, div_lo  in  WIDTH  remainder, quotient
- busy  out  1  high in LAUNCH, WAIT, DONE
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle divide-by-zero pulse
- timeout_err  out  1  one-cycle watchdog pulse
- hi, lo  out  WIDTH  architectural HI/LO

## Operation
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE, start=1:
  - MULT: latch rs→unit_a and rt→unit_b, latch op, go to LAUNCH.
  - DIV with rt_data≠0: same as MULT.
  - DIV with rt_data==0: div_zero=1 next cycle. No start pulse. HI/LO unchanged. Stay IDLE.
  - MTHI/MTLO: write rs_data into hi/lo. done=1 next cycle. Stay IDLE. busy stays 0.
- LAUNCH: assert the start pulse for the latched op only, clear the wait counter, go to WAIT.
- WAIT: watch only the selected unit's done; the other unit's done is ignored.
  - On selected done: capture hi/lo (MULT: mult_hi/mult_lo; DIV: div_hi/div_lo), go to DONE.
  - Counter reaches TIMEOUT with no done: timeout_err=1, HI/LO unchanged, go to IDLE.
  - done and timeout in the same cycle: done wins.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored; there is no queuing.
- Controller does no arithmetic; signedness belongs to the units. Operands are held stable from LAUNCH until IDLE.

## Timing
- Reset values:
  - State IDLE.
  - unit_a, unit_b, hi, lo = 0.
  - All strobes (mult_start, div_start, done, div_zero, timeout_err) and busy = 0.
- All outputs are registered.
- Start sampled at edge N: LAUNCH (start pulse) in cycle N+1, WAIT from N+2.
- Unit done in cycle K: hi/lo valid and done=1 in cycle K+1, IDLE in K+2.
- Earliest next accepted start is sampled at edge K+2.
- MTHI/MTLO and div_zero: single-cycle, result visible the cycle after the sampling edge.
- Reset mid-operation: immediate return to all reset values. Any in-flight unit result is discarded.

## Structure
- Package muldiv_pkg holds:
  - op encodings (OP_MULT, OP_DIV, OP_MTHI, OP_MTLO)
  - state enum
  - default TIMEOUT
- Sub-module muldiv_timer: wait counter with clear, enable and expired outputs, parameterised by TIMEOUT.
- The FSM, operand latches and HI/LO stay in muldiv_ctrl.

## Test plan
- MULT rs=8, rt=5, stub done after 33 cycles → hi=0, lo=40, done one cycle after done, mult_start exactly once, div_start never.
- MULT rs=-3, rt=7 → hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- DIV rs=17, rt=5 → lo=3, hi=2. Spurious mult_done during WAIT is ignored.
- DIV rt=0 with prior hi=1, lo=2 → div_zero pulse, hi=1, lo=2 unchanged, div_start never, busy never high.
- MULT with a stub that never completes, TIMEOUT=40 → timeout_err exactly 40 cycles into WAIT, HI/LO unchanged, IDLE after. A start pulsed during WAIT is ignored.
- Reset asserted in WAIT, then MTHI rs=32'hDEADBEEF → all outputs 0 after reset; after MTHI, hi=32'hDEADBEEF, lo=0, done pulse.
